serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; SHALL be at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 a  input  WIDTH  first operand, captured on the accepting edge.
REQ-006 b  input  WIDTH  second operand, captured on the accepting edge.
REQ-007 busy  output  1  high while in RUN or DONE.
REQ-008 done  output  1  single-cycle pulse, high only in DONE.
REQ-009 sum  output  WIDTH  registered result of a+b mod 2^WIDTH.
REQ-010 c_out  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the next edge SHALL load a and b into shift registers, clear carry and bit counter, and enter RUN.
REQ-013 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-014 In RUN, each cycle SHALL add the operand LSBs with the carry register, shift right both operands, shift the sum bit into the internal sum register from the MSB end, update carry, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles: bit 0 first, bit WIDTH-1 last; when counter = WIDTH-1, the next edge enters DONE.
REQ-016 On entry to DONE, sum and c_out SHALL be loaded from the internal shift register and carry in the same edge.
REQ-017 DONE SHALL last one cycle and unconditionally return to IDLE.
REQ-018 done SHALL assert exactly WIDTH+1 cycles after the edge that accepted start, and no earlier valid result SHALL appear on sum.
REQ-019 start while busy=1, including in the DONE cycle, SHALL be ignored, with no effect on operands or result.
REQ-020 Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-021 sum and c_out SHALL hold the last result until the next DONE entry or reset.
REQ-022 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within one operation.
REQ-023 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-024 reset=1 SHALL, on the next edge, force the state to IDLE and clear operands, carry, counter, sum and c_out to 0, with busy=0 and done=0.
REQ-025 reset SHALL take priority over start and over any state transition, including mid-RUN and in DONE; done SHALL NOT pulse for an aborted operation.

Structure
REQ-026 The default WIDTH and the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared package/include used by the block and its bench.
REQ-027 The one-bit add SHALL be a sub-module, full_adder (a, b, c_in -> c_out, s), built from two half_adder instances and an or_gate.
REQ-028 No other sub-modules are required; the FSM, shift registers and counter are in serial_adder.

Verification
REQ-029 With WIDTH=8, reset for 2 cycles, then start with a=8'h00 and b=8'h00: done pulses 9 cycles after acceptance, sum=8'h00 and c_out=0.
REQ-030 a=8'hFF, b=8'h01 -> sum=8'h00, c_out=1; then a=8'hA5, b=8'h5A -> sum=8'hFF, c_out=0, with busy high for exactly 9 cycles each.
REQ-031 Pulse start with a=8'h10, b=8'h20 during RUN and DONE of an operation on 8'h0F+8'h01 -> only sum=8'h10 is produced and done pulses once.
REQ-032 Assert reset on the 4th RUN cycle of 8'h80+8'h80 -> the next cycle shows IDLE, busy=0, sum=8'h00, c_out=0, and no done pulse.
REQ-033 Hold start=1 continuously with changing operands -> results arrive every 10 cycles, each matching the operands at its acceptance edge.
REQ-034 WIDTH=4, exhaustive 256 operand pairs -> {c_out,sum} equals a+b for every pair, and done latency is 5.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width, FSM encoding
// and the bit-counter sizing rule.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One spare bit so the counter can reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder assembled from two half adders and an OR gate,
// used as the datapath slice of the serial adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic s
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),    .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(c_in), .s(s),  .c(c1));
    or_gate    u_or  (.a(c0), .b(c1),   .y(c_out));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures a and b, adds one bit per cycle LSB first, and
// publishes {c_out, sum} with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   a_sh_q,    a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q,  sum_sh_d;
    logic [WIDTH-1:0]   sum_q,     sum_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               carry_q,   carry_d;
    logic               c_out_q,   c_out_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic fa_s;
    logic fa_c;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .c_out (fa_c),
        .s     (fa_s)
    );

    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = (sum_sh_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                // The final bit lands in the result registers on the same edge.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = sum_sh_d;
                    c_out_d = fa_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule
